// File: rtl/sort_requester.sv
// sort_requester: initiator for the four-entry nth-smallest sorter.
//
// Collects candidate values into groups of up to four. Unused slots are padded
// with all-ones. Each group is issued to the sorter with a rank index, the
// result is captured, and the result is presented downstream. If the sorter
// does not respond within TIMEOUT_CYCLES, a sticky error is raised and the
// group is dropped.
//
// Ports:
//   clk_in, rst_in             clock, asynchronous active-low reset
//   cand_*                     candidate stream in (valid/ready, last closes group)
//   query_index_in             rank requested, sampled with the closing candidate
//   numbers_out, index_out     group and rank to the sorter; slot i at [i*W +: W]
//   sort_valid_out/busy_in     request pulse / sorter busy
//   sort_valid_in, nth_min_in,
//   num_of_mins_in             sorter response
//   result_*, mins_out,
//   group_size_out             captured result to downstream (valid/ready)
//   error_out                  sticky response-timeout flag
module sort_requester #(
  parameter int unsigned MAX_NUM_SIZE   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [MAX_NUM_SIZE-1:0]   cand_in,
  input  logic                      cand_valid_in,
  input  logic                      cand_last_in,
  input  logic [1:0]                query_index_in,
  output logic                      cand_ready_out,
  output logic [4*MAX_NUM_SIZE-1:0] numbers_out,
  output logic [1:0]                index_out,
  output logic                      sort_valid_out,
  input  logic                      sort_busy_in,
  input  logic                      sort_valid_in,
  input  logic [MAX_NUM_SIZE-1:0]   nth_min_in,
  input  logic [1:0]                num_of_mins_in,
  output logic [MAX_NUM_SIZE-1:0]   result_out,
  output logic [1:0]                mins_out,
  output logic [2:0]                group_size_out,
  output logic                      result_valid_out,
  input  logic                      result_ready_in,
  output logic                      error_out
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StCollect, StIssue, StWait, StHold} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              count_q, count_d;
  logic [MAX_NUM_SIZE-1:0] slots_q [4];
  logic [MAX_NUM_SIZE-1:0] slots_d [4];
  logic [1:0]              index_q, index_d;
  logic [2:0]              size_q, size_d;
  logic [TimerW-1:0]       timer_q, timer_d;
  logic [MAX_NUM_SIZE-1:0] result_q, result_d;
  logic [1:0]              mins_q, mins_d;
  logic                    rvalid_q, rvalid_d;
  logic                    error_q, error_d;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= StCollect;
      count_q  <= '0;
      slots_q  <= '{default: '0};
      index_q  <= '0;
      size_q   <= '0;
      timer_q  <= '0;
      result_q <= '0;
      mins_q   <= '0;
      rvalid_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      slots_q  <= slots_d;
      index_q  <= index_d;
      size_q   <= size_d;
      timer_q  <= timer_d;
      result_q <= result_d;
      mins_q   <= mins_d;
      rvalid_q <= rvalid_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    slots_d        = slots_q;
    index_d        = index_q;
    size_d         = size_q;
    timer_d        = timer_q;
    result_d       = result_q;
    mins_d         = mins_q;
    rvalid_d       = rvalid_q;
    error_d        = error_q;
    cand_ready_out = 1'b0;
    sort_valid_out = 1'b0;

    case (state_q)
      StCollect: begin
        cand_ready_out = 1'b1;
        if (cand_valid_in) begin
          slots_d[count_q] = cand_in;
          if (cand_last_in || (count_q == 2'd3)) begin
            // Pad the unused tail so padding never ranks below a real entry.
            for (int i = 0; i < 4; i++) begin
              if (i > int'(count_q)) slots_d[i] = '1;
            end
            size_d  = {1'b0, count_q} + 3'd1;
            // Clamp the rank onto a real entry.
            index_d = (query_index_in > count_q) ? count_q : query_index_in;
            count_d = '0;
            state_d = StIssue;
          end else begin
            count_d = count_q + 2'd1;
          end
        end
      end

      StIssue: begin
        if (!sort_busy_in) begin
          sort_valid_out = 1'b1;
          timer_d        = '0;
          state_d        = StWait;
        end
      end

      StWait: begin
        if (sort_valid_in) begin
          result_d = nth_min_in;
          mins_d   = num_of_mins_in;
          rvalid_d = 1'b1;
          state_d  = StHold;
        end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
          // The timer reaches TIMEOUT_CYCLES this cycle: give up on the group.
          error_d = 1'b1;
          count_d = '0;
          state_d = StCollect;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      StHold: begin
        if (result_ready_in) begin
          rvalid_d = 1'b0;
          count_d  = '0;
          state_d  = StCollect;
        end
      end

      default: state_d = StCollect;
    endcase
  end

  always_comb begin
    numbers_out = '0;
    for (int i = 0; i < 4; i++) begin
      numbers_out[i*MAX_NUM_SIZE +: MAX_NUM_SIZE] = slots_q[i];
    end
  end

  assign index_out        = index_q;
  assign group_size_out   = size_q;
  assign result_out       = result_q;
  assign mins_out         = mins_q;
  assign result_valid_out = rvalid_q;
  assign error_out        = error_q;

endmodule

// File: tb/tb_sort_requester.sv
module tb_sort_requester;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic [31:0]  cand_in;
  logic         cand_valid_in;
  logic         cand_last_in;
  logic [1:0]   query_index_in;
  logic         cand_ready_out;
  logic [127:0] numbers_out;
  logic [1:0]   index_out;
  logic         sort_valid_out;
  logic         sort_busy_in;
  logic         sort_valid_in;
  logic [31:0]  nth_min_in;
  logic [1:0]   num_of_mins_in;
  logic [31:0]  result_out;
  logic [1:0]   mins_out;
  logic [2:0]   group_size_out;
  logic         result_valid_out;
  logic         result_ready_in;
  logic         error_out;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;

  localparam logic [31:0] Ones = 32'hFFFF_FFFF;

  sort_requester #(.MAX_NUM_SIZE(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .cand_in          (cand_in),
    .cand_valid_in    (cand_valid_in),
    .cand_last_in     (cand_last_in),
    .query_index_in   (query_index_in),
    .cand_ready_out   (cand_ready_out),
    .numbers_out      (numbers_out),
    .index_out        (index_out),
    .sort_valid_out   (sort_valid_out),
    .sort_busy_in     (sort_busy_in),
    .sort_valid_in    (sort_valid_in),
    .nth_min_in       (nth_min_in),
    .num_of_mins_in   (num_of_mins_in),
    .result_out       (result_out),
    .mins_out         (mins_out),
    .group_size_out   (group_size_out),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .error_out        (error_out)
  );

  always #5 clk_in = ~clk_in;

  // Request pulses counted on the falling edge, away from input changes.
  always @(negedge clk_in) if (sort_valid_out) pulses++;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_group(input int n, input logic [31:0] v0, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] v3,
                            input logic [1:0] q);
    logic [31:0] v [4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < n; i++) begin
      cand_in        = v[i];
      cand_valid_in  = 1'b1;
      cand_last_in   = (i == n - 1);
      query_index_in = q;
      tick();
    end
    cand_valid_in = 1'b0;
    cand_last_in  = 1'b0;
    #1;
  endtask

  task automatic respond(input logic [31:0] val, input logic [1:0] m);
    sort_valid_in  = 1'b1;
    nth_min_in     = val;
    num_of_mins_in = m;
    tick();
    sort_valid_in  = 1'b0;
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; cand_in = '0; cand_valid_in = 0; cand_last_in = 0; query_index_in = 0;
    sort_busy_in = 0; sort_valid_in = 0; nth_min_in = '0; num_of_mins_in = '0;
    result_ready_in = 0;
    tick(); tick();
    check("rst_cand_ready", cand_ready_out, 1);
    check("rst_numbers", numbers_out, 0);
    check("rst_outputs", {sort_valid_out, result_valid_out, error_out, group_size_out,
                          index_out, result_out, mins_out}, 0);
    rst_in = 1'b1;
    tick();

    // Full group 7,3,9,1 with rank 1.
    p0 = pulses;
    send_group(4, 7, 3, 9, 1, 2'd1);
    check("full_pulse", sort_valid_out, 1);
    check("full_numbers", numbers_out, {32'd1, 32'd9, 32'd3, 32'd7});
    check("full_index", index_out, 1);
    check("full_size", group_size_out, 4);
    check("full_ready_low", cand_ready_out, 0);
    tick();
    check("full_pulse_once", sort_valid_out, 0);
    tick(); tick(); tick(); tick();
    respond(32'd3, 2'd1);
    check("full_result", {result_valid_out, result_out, mins_out}, {1'b1, 32'd3, 2'd1});
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
    check("full_done", {result_valid_out, cand_ready_out}, 2'b01);
    check("full_pulse_count", pulses - p0, 1);

    // Short group 5,2 with rank 3, clamped to 1; then backpressure.
    send_group(2, 5, 2, 0, 0, 2'd3);
    check("short_numbers", numbers_out, {Ones, Ones, 32'd2, 32'd5});
    check("short_index", index_out, 1);
    check("short_size", group_size_out, 2);
    tick(); tick();
    respond(32'd5, 2'd1);
    check("short_result", {result_valid_out, result_out}, {1'b1, 32'd5});
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_hold", {result_valid_out, result_out, cand_ready_out}, {1'b1, 32'd5, 1'b0});
    end
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
    check("bp_release", {result_valid_out, cand_ready_out}, 2'b01);

    // Busy stall for 10 cycles after close.
    sort_busy_in = 1'b1;
    p0 = pulses;
    send_group(4, 10, 20, 30, 40, 2'd0);
    check("stall_no_pulse0", sort_valid_out, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("stall_no_pulse", sort_valid_out, 0);
    end
    sort_busy_in = 1'b0;
    #1;
    check("stall_pulse", sort_valid_out, 1);
    check("stall_numbers", numbers_out, {32'd40, 32'd30, 32'd20, 32'd10});
    tick();
    check("stall_pulse_count", pulses - p0, 1);
    respond(32'd10, 2'd1);
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;

    // Timeout: sorter never answers.
    send_group(3, 1, 2, 3, 0, 2'd2);
    check("to_numbers", numbers_out, {Ones, 32'd3, 32'd2, 32'd1});
    check("to_index_size", {index_out, group_size_out}, {2'd2, 3'd3});
    for (int i = 0; i < 16; i++) tick();
    check("to_not_yet", {error_out, cand_ready_out}, 2'b00);
    tick();
    check("to_error", {error_out, cand_ready_out}, 2'b11);
    respond(32'd99, 2'd1);
    tick();
    check("to_stray_ignored", result_valid_out, 0);
    check("to_sticky", error_out, 1);

    // Reset while waiting on the sorter.
    send_group(4, 8, 6, 4, 2, 2'd3);
    tick();
    rst_in = 1'b0;
    #1;
    check("rstw_outputs", {numbers_out, index_out, group_size_out, result_out, mins_out,
                           result_valid_out, error_out, sort_valid_out}, 0);
    check("rstw_ready", cand_ready_out, 1);
    tick();
    rst_in = 1'b1;
    p0 = pulses;
    tick(); tick();
    check("rstw_no_pulse", pulses - p0, 0);
    send_group(4, 8, 6, 4, 2, 2'd3);
    check("rstw_new_group", {sort_valid_out, index_out, group_size_out}, {1'b1, 2'd3, 3'd4});
    check("rstw_numbers", numbers_out, {32'd2, 32'd4, 32'd6, 32'd8});
    tick(); tick();
    respond(32'd8, 2'd1);
    check("rstw_result", {result_valid_out, result_out, mins_out, error_out},
          {1'b1, 32'd8, 2'd1, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
